spi_line_fetcher: RTL and testbench

SPI flash line fetcher for the VGA SPI ROM display path. On a request it issues a standard READ (03h) with a 24-bit address to the SPI ROM, shifts in a fixed number of data bits, and holds them in a line buffer. The pixel stage reads that buffer by bit index while scanning the line. It sits directly upstream of the display/pixel logic and replaces ad-hoc SPI sequencing tied to `hpos`.

---
 rtl/spi_line_fetcher.sv | 137 +++++++++++++
 tb/tb_spi_line_fetcher.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_line_fetcher.sv
// SPI ROM line fetcher: issues READ {CMD, addr}, shifts DEPTH data bits into a line buffer.
// Define SPI_LINE_FETCHER_DOUBLE_BUFFER_EN for a front/back bank pair swapped at DONE.
`timescale 1ns/1ps

module spi_line_fetcher #(
    parameter int         DEPTH = 192,
    parameter logic [7:0] CMD   = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    input  logic [8:0]  rd_index,
    output logic        rd_data,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int            CW         = $clog2(32 + DEPTH);
    localparam logic [CW-1:0] N_LAST     = CW'(31 + DEPTH);
    localparam logic [CW-1:0] N_CMD_LAST = CW'(31);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     n;
    logic [30:0]       shift_rest;
    logic              sclk_q;
    logic              mosi_q;
    logic              last_bit;
    logic [DEPTH-1:0]  wr_buf;
    logic [DEPTH-1:0]  rd_buf;
    logic [511:0]      rd_vec;

    // sclk_q high means the rising edge for bit n has just been issued
    assign last_bit = sclk_q && (n == N_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = XFER;
            XFER:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        spi_cs = 1'b0;
        case (state)
            XFER: begin
                busy   = 1'b1;
                spi_cs = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // mosi_q holds the bit on the wire; shift_rest holds the bits still to send
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n          <= '0;
            shift_rest <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            wr_buf     <= '0;
`ifdef SPI_LINE_FETCHER_DOUBLE_BUFFER_EN
            rd_buf     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (req) begin
                        n          <= '0;
                        shift_rest <= {CMD[6:0], addr};
                        mosi_q     <= CMD[7];
                    end
                end
                XFER: begin
                    sclk_q <= ~sclk_q;
                    if (!sclk_q) begin
                        if (n > N_CMD_LAST) begin
                            wr_buf <= {wr_buf[DEPTH-2:0], spi_miso};
                        end
                    end else if (last_bit) begin
                        mosi_q <= 1'b0;
`ifdef SPI_LINE_FETCHER_DOUBLE_BUFFER_EN
                        // back bank is fully rewritten each fetch, so a copy acts as the swap
                        rd_buf <= wr_buf;
`endif
                    end else begin
                        n          <= n + CW'(1);
                        shift_rest <= {shift_rest[29:0], 1'b0};
                        mosi_q     <= (n < N_CMD_LAST) ? shift_rest[30] : 1'b0;
                    end
                end
                default: begin
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef SPI_LINE_FETCHER_DOUBLE_BUFFER_EN
    assign rd_buf = wr_buf;
`endif

    // zero-extension makes every index >= DEPTH read back as 0
    assign rd_vec   = 512'(rd_buf);
    assign rd_data  = rd_vec[rd_index];
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_line_fetcher.sv
// Scoreboard bench for spi_line_fetcher: ROM model on the SPI pins, queue of expected transactions.
`timescale 1ns/1ps

module tb_spi_line_fetcher;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [23:0] addr;
    logic        busy;
    logic        done;
    logic [8:0]  rd_index;
    logic        rd_data;
    logic        spi_cs;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

`ifdef SPI_LINE_FETCHER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    spi_line_fetcher dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .rd_index (rd_index),
        .rd_data  (rd_data),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM model: captures the 32 command/address bits, returns a byte pattern chosen by address
    int          rom_bits = 0;
    logic [31:0] rom_word = '0;

    always @(posedge spi_cs) begin
        rom_bits = 0;
        rom_word = '0;
    end

    always @(posedge spi_sclk) begin
        if (spi_cs) begin
            if (rom_bits < 32) rom_word = {rom_word[30:0], spi_mosi};
            rom_bits++;
        end
    end

    always @(negedge spi_sclk) begin
        int   j;
        int   bi;
        logic [7:0] rb;
        if (spi_cs && rom_bits >= 32) begin
            j  = rom_bits - 32;
            rb = (rom_word[23:0] == 24'h000120) ? 8'hA5 : rom_word[7:0];
            bi = 7 - (j % 8);
            spi_miso = rb[bi[2:0]];
        end
    end

    typedef struct {
        logic [31:0] word;
        int          gap;
    } exp_t;

    exp_t exp_q[$];

    // monitor: frames each CS window and pops one expectation per done pulse
    int   cyc = 0;
    int   accept_cyc = 0;
    int   last_accept = 0;
    int   cs_cnt = 0;
    int   rises = 0;
    int   sclk_bad = 0;
    logic prev_cs = 1'b0;
    logic prev_sclk = 1'b0;

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (spi_cs && !prev_cs) begin
            if (exp_q.size() > 0 && exp_q[0].gap != 0)
                check("accept_gap", 32'(cyc - last_accept), 32'(exp_q[0].gap));
            last_accept = cyc;
            accept_cyc  = cyc;
            cs_cnt      = 0;
            rises       = 0;
        end
        if (spi_cs) begin
            cs_cnt++;
            if (spi_sclk && !prev_sclk) rises++;
        end
        if (!spi_cs && spi_sclk) sclk_bad++;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check("mosi_word", rom_word, e.word);
                check("cs_cycles", 32'(cs_cnt), 32'd448);
                check("sclk_rises", 32'(rises), 32'd224);
                check("done_latency", 32'(cyc - accept_cyc), 32'd448);
            end
        end
        prev_cs   = spi_cs;
        prev_sclk = spi_sclk;
    end

    task automatic rd_check(input string name, input int idx, input logic exp);
        rd_index = 9'(idx);
        #0.5;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic read_byte(input string name, input logic [7:0] b);
        for (int k = 0; k < 8; k++) rd_check(name, 191 - k, b[7-k]);
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #(40 * 6000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        reset_n  = 1'b0;
        req      = 1'b0;
        addr     = '0;
        rd_index = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(spi_cs), 32'd0);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // basic fetch, then req pulse/hold while busy
        @(negedge clk);
        req  = 1'b1;
        addr = 24'h000120;
        exp_q.push_back('{32'h03000120, 0});
        @(posedge clk);
        #1;
        check("e0_cs", 32'(spi_cs), 32'd1);
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_sclk", 32'(spi_sclk), 32'd0);
        check("e0_mosi", 32'(spi_mosi), 32'd0);
        @(negedge clk);
        req  = 1'b0;
        addr = 24'h000000;
        repeat (99) @(posedge clk);
        @(negedge clk);
        req  = 1'b1;
        addr = 24'hFFFFFF;
        exp_q.push_back('{32'h03FFFFFF, 450});
        wait_done("t1_done");
        read_byte("t1_line", 8'hA5);
        rd_check("t1_oor_192", 192, 1'b0);
        rd_check("t1_oor_511", 511, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_req_busy", 32'(busy), 32'd1);
        @(negedge clk) req = 1'b0;
        wait_done("t2_done");
        read_byte("t2_line", 8'hFF);
        rd_check("t2_oor_511", 511, 1'b0);

        // zero line over an all-ones line: bank isolation
        @(posedge clk);
        @(negedge clk);
        req  = 1'b1;
        addr = 24'h000000;
        exp_q.push_back('{32'h03000000, 0});
        @(posedge clk);
        @(negedge clk) req = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rd_check("t3_rd0_e100", 0, logic'(DB));
        repeat (200) @(posedge clk);
        #1;
        rd_check("t3_rd191_e300", 191, 1'b1);
        repeat (147) @(posedge clk);
        #1;
        rd_check("t3_rd191_e447", 191, logic'(DB));
        @(posedge clk);
        #1;
        check("t3_done_e448", 32'(done), 32'd1);
        rd_check("t3_rd191_e448", 191, 1'b0);

        // reset mid-transfer
        @(posedge clk);
        @(negedge clk);
        req  = 1'b1;
        addr = 24'h000120;
        @(posedge clk);
        @(negedge clk) req = 1'b0;
        repeat (199) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs", 32'(spi_cs), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        nz = 0;
        for (int i = 0; i < 192; i++) begin
            rd_index = 9'(i);
            #0.05;
            if (rd_data !== 1'b0) nz++;
        end
        check("abort_rd_nonzero_count", 32'(nz), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // fresh fetch after the abort
        @(negedge clk);
        req  = 1'b1;
        addr = 24'h0000C3;
        exp_q.push_back('{32'h030000C3, 0});
        @(posedge clk);
        @(negedge clk) req = 1'b0;
        wait_done("t5_done");
        read_byte("t5_line", 8'hC3);
        rd_check("t5_oor_192", 192, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("sclk_low_when_cs_low", 32'(sclk_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
